hwpe_stream_merge_buffered: RTL and testbench

- Parametrised successor to the combinational stream merge.
- Concatenates NB_IN_STREAMS narrow HWPE streams into one wide output stream.
- Each input lane has its own LANE_DEPTH-entry FIFO, so lanes may deliver beats on different cycles. An output beat forms only when every enabled lane has data.
- Sits between per-lane streamers/sources and wide consumers such as engine datapaths or TCDM wide ports. A runtime lane-enable mask supports partial merges.

---
 rtl/hwpe_stream_merge_buffered.sv | 136 +++++++++++++
 tb/tb_hwpe_stream_merge_buffered.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_merge_buffered.sv
`default_nettype none
// ============================================================================
// hwpe_stream_merge_buffered: per-lane FIFOs merged into one wide stream.
// Revision: 1.0
// ============================================================================
module hwpe_stream_merge_buffered #(
  parameter int unsigned DATA_WIDTH_IN  = 32,
  parameter int unsigned NB_IN_STREAMS  = 2,
  parameter int unsigned LANE_DEPTH     = 2,
  localparam int unsigned STRB_WIDTH_IN  = DATA_WIDTH_IN / 8,
  localparam int unsigned DATA_WIDTH_OUT = DATA_WIDTH_IN * NB_IN_STREAMS,
  localparam int unsigned STRB_WIDTH_OUT = DATA_WIDTH_OUT / 8
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     clear_i,
  input  logic [NB_IN_STREAMS-1:0]                 lane_en_i,
  input  logic [NB_IN_STREAMS-1:0]                 push_valid_i,
  output logic [NB_IN_STREAMS-1:0]                 push_ready_o,
  input  logic [NB_IN_STREAMS*DATA_WIDTH_IN-1:0]   push_data_i,
  input  logic [NB_IN_STREAMS*STRB_WIDTH_IN-1:0]   push_strb_i,
  output logic                                     pop_valid_o,
  input  logic                                     pop_ready_i,
  output logic [DATA_WIDTH_OUT-1:0]                pop_data_o,
  output logic [STRB_WIDTH_OUT-1:0]                pop_strb_o,
  output logic [NB_IN_STREAMS-1:0]                 lane_empty_o,
  output logic [31:0]                              beat_cnt_o
);

  localparam int unsigned CNT_W = $clog2(LANE_DEPTH + 1);
  localparam int unsigned PTR_W = (LANE_DEPTH > 1) ? $clog2(LANE_DEPTH) : 1;
  localparam logic [CNT_W-1:0] c_lane_full = CNT_W'(LANE_DEPTH);
  localparam logic [PTR_W-1:0] c_last_ptr  = PTR_W'(LANE_DEPTH - 1);

  logic                     w_pop_fire;
  logic [NB_IN_STREAMS-1:0] w_lane_empty;
  logic [NB_IN_STREAMS-1:0] w_lane_ok;
  logic [31:0]              r_beat_cnt;

  assign w_pop_fire = pop_valid_o & pop_ready_i;

  generate
    for (genvar i = 0; i < NB_IN_STREAMS; i++) begin : g_lane
      logic [DATA_WIDTH_IN-1:0] r_data_mem [LANE_DEPTH];
      logic [STRB_WIDTH_IN-1:0] r_strb_mem [LANE_DEPTH];
      logic [PTR_W-1:0]         r_wr_ptr;
      logic [PTR_W-1:0]         r_rd_ptr;
      logic [CNT_W-1:0]         r_cnt;
      logic                     w_push;
      logic                     w_pop;
      logic                     w_head_vis;

      // Ready depends only on local occupancy, never on pop_ready_i.
      assign push_ready_o[i] = (r_cnt != c_lane_full);
      assign w_push          = push_valid_i[i] & push_ready_o[i] & ~clear_i;
      assign w_pop           = w_pop_fire & lane_en_i[i] & ~clear_i;
      assign w_lane_empty[i] = (r_cnt == '0);
      assign w_lane_ok[i]    = ~lane_en_i[i] | ~w_lane_empty[i];
      assign w_head_vis      = lane_en_i[i] & ~w_lane_empty[i];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_cnt    <= '0;
        end else if (clear_i) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_cnt    <= '0;
        end else begin
          if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + PTR_W'(1);
          end
          if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + PTR_W'(1);
          end
          if (w_push && !w_pop) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else if (!w_push && w_pop) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
      end

      // Storage needs no reset: an empty lane never exposes its head.
      always_ff @(posedge clk_i) begin
        if (w_push) begin
          r_data_mem[r_wr_ptr] <= push_data_i[i*DATA_WIDTH_IN +: DATA_WIDTH_IN];
          r_strb_mem[r_wr_ptr] <= push_strb_i[i*STRB_WIDTH_IN +: STRB_WIDTH_IN];
        end
      end

      assign pop_data_o[i*DATA_WIDTH_IN +: DATA_WIDTH_IN] =
        w_head_vis ? r_data_mem[r_rd_ptr] : '0;
      assign pop_strb_o[i*STRB_WIDTH_IN +: STRB_WIDTH_IN] =
        w_head_vis ? r_strb_mem[r_rd_ptr] : '0;

`ifndef SYNTHESIS
      a_push_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (push_valid_i[i] && !push_ready_o[i]) |=>
          (!push_valid_i[i] ||
           ($stable(push_data_i[i*DATA_WIDTH_IN +: DATA_WIDTH_IN]) &&
            $stable(push_strb_i[i*STRB_WIDTH_IN +: STRB_WIDTH_IN]))))
        else $error("push lane %0d changed data while stalled", i);
`endif
    end
  endgenerate

  // An all-disabled mask would otherwise AND to 1 and emit empty beats.
  assign pop_valid_o  = (|lane_en_i) & (&w_lane_ok);
  assign lane_empty_o = w_lane_empty;
  assign beat_cnt_o   = r_beat_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_beat_cnt <= '0;
    end else if (clear_i) begin
      r_beat_cnt <= '0;
    end else if (w_pop_fire) begin
      r_beat_cnt <= r_beat_cnt + 32'd1;
    end
  end

`ifndef SYNTHESIS
  a_pop_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (pop_valid_o && !pop_ready_i && !clear_i) |=>
      ($stable(pop_data_o) && $stable(pop_strb_o)))
    else $error("pop data changed while stalled");

  a_lane_en_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (pop_valid_o && !pop_ready_i && !clear_i) |=> $stable(lane_en_i))
    else $error("lane_en_i changed while output valid");
`endif

endmodule
`default_nettype wire

// File: tb/tb_hwpe_stream_merge_buffered.sv
`default_nettype none
// ============================================================================
// tb_hwpe_stream_merge_buffered: directed and random checks against a queue model.
// Revision: 1.0
// ============================================================================
module tb_hwpe_stream_merge_buffered;

  localparam int W  = 8;
  localparam int NB = 4;
  localparam int D  = 2;
  localparam int SW = 1;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              clear_i;
  logic [NB-1:0]     lane_en_i;
  logic [NB-1:0]     push_valid_i;
  logic [NB-1:0]     push_ready_o;
  logic [NB*W-1:0]   push_data_i;
  logic [NB*SW-1:0]  push_strb_i;
  logic              pop_valid_o;
  logic              pop_ready_i;
  logic [NB*W-1:0]   pop_data_o;
  logic [NB*SW-1:0]  pop_strb_o;
  logic [NB-1:0]     lane_empty_o;
  logic [31:0]       beat_cnt_o;

  hwpe_stream_merge_buffered #(
    .DATA_WIDTH_IN (W),
    .NB_IN_STREAMS (NB),
    .LANE_DEPTH    (D)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .lane_en_i    (lane_en_i),
    .push_valid_i (push_valid_i),
    .push_ready_o (push_ready_o),
    .push_data_i  (push_data_i),
    .push_strb_i  (push_strb_i),
    .pop_valid_o  (pop_valid_o),
    .pop_ready_i  (pop_ready_i),
    .pop_data_o   (pop_data_o),
    .pop_strb_o   (pop_strb_o),
    .lane_empty_o (lane_empty_o),
    .beat_cnt_o   (beat_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: one queue of {strb,data} per lane plus a beat counter.
  logic [W+SW-1:0] mq [NB][$];
  logic [31:0]     m_cnt;
  logic [NB-1:0]   last_acc;
  logic            prev_clear;

  function automatic logic m_valid();
    logic ok;
    ok = (lane_en_i != '0);
    for (int i = 0; i < NB; i++)
      if (lane_en_i[i] && mq[i].size() == 0) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [NB*W-1:0] m_data();
    logic [NB*W-1:0] d;
    logic [W+SW-1:0] e;
    d = '0;
    for (int i = 0; i < NB; i++)
      if (lane_en_i[i] && mq[i].size() > 0) begin
        e = mq[i][0];
        d[i*W +: W] = e[W-1:0];
      end
    return d;
  endfunction

  function automatic logic [NB-1:0] m_strb();
    logic [NB-1:0]   s;
    logic [W+SW-1:0] e;
    s = '0;
    for (int i = 0; i < NB; i++)
      if (lane_en_i[i] && mq[i].size() > 0) begin
        e = mq[i][0];
        s[i] = e[W];
      end
    return s;
  endfunction

  function automatic logic [NB-1:0] m_ready();
    logic [NB-1:0] r;
    for (int i = 0; i < NB; i++) r[i] = (mq[i].size() < D);
    return r;
  endfunction

  function automatic logic [NB-1:0] m_empty();
    logic [NB-1:0] e;
    for (int i = 0; i < NB; i++) e[i] = (mq[i].size() == 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("push_ready", push_ready_o, m_ready());
    chk("lane_empty", lane_empty_o, m_empty());
    chk("pop_valid",  pop_valid_o,  m_valid());
    chk("beat_cnt",   beat_cnt_o,   m_cnt);
    if (m_valid()) begin
      chk("pop_data", pop_data_o, m_data());
      chk("pop_strb", pop_strb_o, m_strb());
    end
  endtask

  task automatic model_flush();
    for (int i = 0; i < NB; i++) mq[i].delete();
    m_cnt = '0;
  endtask

  task automatic cycle();
    logic [NB-1:0] pf;
    logic          popf;
    pf   = push_valid_i & m_ready();
    popf = m_valid() & pop_ready_i;
    @(posedge clk_i);
    if (clear_i) begin
      model_flush();
    end else begin
      if (popf) begin
        for (int i = 0; i < NB; i++)
          if (lane_en_i[i]) void'(mq[i].pop_front());
        m_cnt++;
      end
      for (int i = 0; i < NB; i++)
        if (pf[i]) mq[i].push_back({push_strb_i[i], push_data_i[i*W +: W]});
    end
    last_acc   = pf;
    prev_clear = clear_i;
    #1;
    check_outputs();
  endtask

  task automatic idle();
    push_valid_i = '0;
    clear_i      = 1'b0;
  endtask

  task automatic put(input int l, input logic [W-1:0] d);
    push_valid_i[l]     = 1'b1;
    push_data_i[l*W +: W] = d;
    push_strb_i[l]      = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, pop_valid_o, 1'b0);
    chk({tag, "_data"},  pop_data_o,  32'h0);
    chk({tag, "_strb"},  pop_strb_o,  4'h0);
    chk({tag, "_empty"}, lane_empty_o, 4'hF);
    chk({tag, "_cnt"},   beat_cnt_o,  32'h0);
  endtask

  initial begin
    rst_ni       = 1'b0;
    clear_i      = 1'b0;
    lane_en_i    = 4'b0011;
    push_valid_i = '0;
    push_data_i  = '0;
    push_strb_i  = '0;
    pop_ready_i  = 1'b1;
    last_acc     = '0;
    prev_clear   = 1'b0;
    model_flush();
    #2;
    check_reset_values("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Aligned streams
    put(0, 8'h11); put(1, 8'h22);
    cycle();
    idle();
    chk("aligned_valid", pop_valid_o, 1'b1);
    chk("aligned_data",  pop_data_o,  32'h0000_2211);
    chk("aligned_strb",  pop_strb_o,  4'b0011);
    cycle();
    chk("aligned_cnt", beat_cnt_o, 32'd1);

    // Skewed arrival
    put(0, 8'hAA);
    cycle();
    idle();
    cycle();
    cycle();
    chk("skew_wait_valid", pop_valid_o, 1'b0);
    chk("skew_ready0",     push_ready_o[0], 1'b1);
    put(1, 8'hBB);
    cycle();
    idle();
    chk("skew_data", pop_data_o, 32'h0000_BBAA);
    cycle();
    chk("skew_cnt", beat_cnt_o, 32'd2);

    // Backpressure / full
    pop_ready_i = 1'b0;
    put(0, 8'h01); put(1, 8'h10);
    cycle();
    put(0, 8'h02); put(1, 8'h20);
    cycle();
    chk("full_ready0", push_ready_o[0], 1'b0);
    idle();
    put(0, 8'h03);
    cycle();
    idle();
    chk("full_head", pop_data_o, 32'h0000_1001);
    pop_ready_i = 1'b1;
    cycle();
    chk("full_pop2_valid", pop_valid_o, 1'b1);
    chk("full_pop2_data",  pop_data_o,  32'h0000_2002);
    cycle();
    chk("full_drained", pop_valid_o, 1'b0);
    chk("full_cnt",     beat_cnt_o,  32'd4);

    // Lane mask
    lane_en_i   = 4'b0101;
    pop_ready_i = 1'b0;
    put(0, 8'h01); put(2, 8'h03); put(1, 8'h55);
    cycle();
    idle();
    chk("mask_data",   pop_data_o, 32'h0003_0001);
    chk("mask_strb",   pop_strb_o, 4'b0101);
    chk("mask_keep1",  lane_empty_o[1], 1'b0);
    pop_ready_i = 1'b1;
    cycle();

    // Clear mid-stream
    lane_en_i   = 4'b0011;
    pop_ready_i = 1'b0;
    put(0, 8'h66);
    cycle();
    idle();
    chk("clr_pre_data", pop_data_o, 32'h0000_5566);
    chk("clr_pre_cnt",  beat_cnt_o, 32'd5);
    clear_i     = 1'b1;
    pop_ready_i = 1'b1;
    put(0, 8'h77); put(1, 8'h88);
    cycle();
    idle();
    chk("clr_empty", lane_empty_o, 4'hF);
    chk("clr_valid", pop_valid_o,  1'b0);
    chk("clr_cnt",   beat_cnt_o,   32'd0);

    // Random traffic
    last_acc = '0;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NB; i++)
        if (!push_valid_i[i] || last_acc[i]) begin
          push_valid_i[i]       = 1'($urandom_range(0, 1));
          push_data_i[i*W +: W] = 8'($urandom);
          push_strb_i[i]        = 1'($urandom_range(0, 1));
        end
      pop_ready_i = ($urandom_range(0, 3) != 0);
      clear_i     = ($urandom_range(0, 39) == 0);
      if (!m_valid() && !prev_clear && $urandom_range(0, 7) == 0)
        lane_en_i = 4'($urandom);
      cycle();
    end
    idle();
    clear_i = 1'b1;
    cycle();
    idle();

    // Asynchronous reset with beats queued
    lane_en_i   = 4'b0011;
    pop_ready_i = 1'b0;
    put(0, 8'h5A); put(1, 8'hA5);
    cycle();
    idle();
    chk("ar_pre_valid", pop_valid_o, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_flush();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni      = 1'b1;
    pop_ready_i = 1'b1;
    put(0, 8'h33); put(1, 8'h44);
    cycle();
    idle();
    chk("ar_post_data", pop_data_o, 32'h0000_4433);
    cycle();
    chk("ar_post_cnt", beat_cnt_o, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
